// File: rtl/pio_cmd_initiator_if.sv
// Command/response handshake plus PIO register bus between the initiator and its environment.
// master: the initiator itself; slave: command source, response sink and PIO responder.
interface pio_cmd_initiator_if;
    logic        cmd_valid;
    logic        cmd_ready;
    logic        cmd_we;
    logic [9:0]  cmd_regnum;
    logic [19:0] cmd_addr;
    logic [31:0] cmd_wdata;
    logic        cmd_poll;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic        rsp_timeout;
    logic        busy;
    logic [31:0] pio_cmd;
    logic [31:0] pio_wdata;
    logic [31:0] pio_rdata;

    modport master (
        input  cmd_valid, cmd_we, cmd_regnum, cmd_addr, cmd_wdata, cmd_poll,
        input  rsp_ready, pio_rdata,
        output cmd_ready, rsp_valid, rsp_rdata, rsp_timeout, busy, pio_cmd, pio_wdata
    );

    modport slave (
        output cmd_valid, cmd_we, cmd_regnum, cmd_addr, cmd_wdata, cmd_poll,
        output rsp_ready, pio_rdata,
        input  cmd_ready, rsp_valid, rsp_rdata, rsp_timeout, busy, pio_cmd, pio_wdata
    );
endinterface

// File: rtl/pio_cmd_initiator.sv
// Initiator for the FPGA PIO register protocol: valid/ready commands -> command/data words, read data back.
// Optional build macro PIO_RD_POLL_EN enables polled reads (resample until nonzero or POLL_MAX samples).
module pio_cmd_initiator #(
    parameter int unsigned HOLD_CYCLES = 2,
    parameter int unsigned READ_LAT    = 3,
    parameter logic [9:0]  IDLE_REGNUM = 10'h3FF,
    parameter int unsigned POLL_MAX    = 1024
) (
    input logic                 clk,
    input logic                 reset,
    pio_cmd_initiator_if.master bus
);
    localparam int unsigned MAX_LAT   = (HOLD_CYCLES > READ_LAT) ? HOLD_CYCLES : READ_LAT;
    localparam int unsigned CNT_W     = $clog2(MAX_LAT + 1);
    localparam int unsigned SAMP_W    = 11;
    localparam logic [31:0] IDLE_WORD = {2'b00, IDLE_REGNUM, 20'h0};

    if (HOLD_CYCLES == 0 || READ_LAT == 0 || POLL_MAX == 0 || POLL_MAX > 1024) begin : g_param_check
        $error("pio_cmd_initiator: illegal parameter value");
    end

    typedef enum logic [2:0] {
        S_IDLE, S_SETUP, S_STROBE, S_RELEASE, S_RD_WAIT, S_RESP
    } state_e;

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [9:0]         regnum_q, regnum_d;
    logic [19:0]        addr_q, addr_d;
    logic               cmd_ready_q, cmd_ready_d;
    logic               busy_q, busy_d;
    logic               rsp_valid_q, rsp_valid_d;
    logic [31:0]        rsp_rdata_q, rsp_rdata_d;
    logic [31:0]        pio_cmd_q, pio_cmd_d;
    logic [31:0]        pio_wdata_q, pio_wdata_d;
    logic               accept;
`ifdef PIO_RD_POLL_EN
    logic               poll_q, poll_d;
    logic [SAMP_W-1:0]  samp_q, samp_d;
    logic               rsp_timeout_q, rsp_timeout_d;
`else
    logic               unused_poll;
    assign unused_poll = bus.cmd_poll;
`endif

    assign accept = cmd_ready_q && bus.cmd_valid;

    // Next state; every output flop is loaded from a decode of the next state.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        regnum_d    = regnum_q;
        addr_d      = addr_q;
        rsp_rdata_d = rsp_rdata_q;
        pio_wdata_d = pio_wdata_q;
`ifdef PIO_RD_POLL_EN
        poll_d        = poll_q;
        samp_d        = samp_q;
        rsp_timeout_d = rsp_timeout_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    regnum_d = bus.cmd_regnum;
                    addr_d   = bus.cmd_addr;
                    cnt_d    = '0;
                    if (bus.cmd_we) begin
                        state_d     = S_SETUP;
                        pio_wdata_d = bus.cmd_wdata;
                    end else begin
                        state_d = S_RD_WAIT;
`ifdef PIO_RD_POLL_EN
                        poll_d = bus.cmd_poll;
                        samp_d = '0;
`endif
                    end
                end
            end
            S_SETUP: begin
                state_d = S_STROBE;
                cnt_d   = '0;
            end
            S_STROBE: begin
                if (cnt_q == CNT_W'(HOLD_CYCLES - 1)) state_d = S_RELEASE;
                else                                  cnt_d   = cnt_q + CNT_W'(1);
            end
            S_RELEASE: state_d = S_IDLE;
            S_RD_WAIT: begin
                if (cnt_q == CNT_W'(READ_LAT - 1)) begin
                    cnt_d       = '0;
                    rsp_rdata_d = bus.pio_rdata;
`ifdef PIO_RD_POLL_EN
                    // Keep the read word up and resample while a polled read still sees zero.
                    if (poll_q && (bus.pio_rdata == 32'h0) &&
                        ((samp_q + SAMP_W'(1)) < SAMP_W'(POLL_MAX))) begin
                        samp_d = samp_q + SAMP_W'(1);
                    end else begin
                        state_d       = S_RESP;
                        rsp_timeout_d = poll_q && (bus.pio_rdata == 32'h0);
                    end
`else
                    state_d = S_RESP;
`endif
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_RESP: begin
                if (bus.rsp_ready) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        cmd_ready_d = (state_d == S_IDLE);
        busy_d      = (state_d != S_IDLE);
        rsp_valid_d = (state_d == S_RESP);
        case (state_d)
            S_STROBE:         pio_cmd_d = {1'b0, 1'b1, regnum_d, addr_d};
            S_RD_WAIT, S_RESP: pio_cmd_d = {1'b0, 1'b0, regnum_d, addr_d};
            default:          pio_cmd_d = IDLE_WORD;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            regnum_q    <= '0;
            addr_q      <= '0;
            cmd_ready_q <= 1'b0;
            busy_q      <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            pio_cmd_q   <= IDLE_WORD;
            pio_wdata_q <= '0;
`ifdef PIO_RD_POLL_EN
            poll_q        <= 1'b0;
            samp_q        <= '0;
            rsp_timeout_q <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            regnum_q    <= regnum_d;
            addr_q      <= addr_d;
            cmd_ready_q <= cmd_ready_d;
            busy_q      <= busy_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            pio_cmd_q   <= pio_cmd_d;
            pio_wdata_q <= pio_wdata_d;
`ifdef PIO_RD_POLL_EN
            poll_q        <= poll_d;
            samp_q        <= samp_d;
            rsp_timeout_q <= rsp_timeout_d;
`endif
        end
    end

    assign bus.cmd_ready = cmd_ready_q;
    assign bus.busy      = busy_q;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_rdata = rsp_rdata_q;
    assign bus.pio_cmd   = pio_cmd_q;
    assign bus.pio_wdata = pio_wdata_q;
`ifdef PIO_RD_POLL_EN
    assign bus.rsp_timeout = rsp_timeout_q;
`else
    assign bus.rsp_timeout = 1'b0;
`endif
endmodule
